hash_lookup_sched: RTL and testbench
====================================

// Module: hash_lookup_sched
// PURPOSE
//  Schedules shared use of the single two-beat hash engine (hash_function) between NUM_REQ key requesters.
//  - Round-robin arbitrates among requesters and drives the engine's key port.
//  - Collects both hash beats and emits one lookup descriptor per key to the table-read stage.
//  - Sits between the packet key extractors and the hash-table memory controller.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  KEY_W        40   key width
//  HASH_W       9    width of each hash index
//  ID_W         2    requester id width, = $clog2(NUM_REQ)
//  TIMEOUT_CYC  16   watchdog limit in cycles (used only with HASH_TIMEOUT_EN)
// PORTS
//  clk            in   1               clock, rising edge
//  reset          in   1               asynchronous reset, active-high
//  req_valid      in   NUM_REQ         per-requester key valid
//  req_key        in   NUM_REQ*KEY_W   per-requester key; requester i at [i*KEY_W +: KEY_W]
//  req_ready      out  NUM_REQ         one-hot accept; high only for the granted requester
//  hf_key_valid   out  1               key strobe to the hash engine
//  hf_key         out  KEY_W           key to the hash engine
//  hf_hash_valid  in   1               hash beat valid from the engine
//  hf_hash_1..3   in   HASH_W each     hash indices from the engine
//  lk_valid       out  1               lookup descriptor valid
//  lk_ready       in   1               downstream accepts the descriptor
//  lk_id          out  ID_W            originating requester
//  lk_key         out  KEY_W           original key
//  lk_idx_a       out  3*HASH_W        beat-0 indices {h3,h2,h1}
//  lk_idx_b       out  3*HASH_W        beat-1 indices {h3,h2,h1}
//  err_seq        out  1               one-cycle pulse: beat MSB out of order
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; round-robin pointer = requester 0.
//  States and transitions:
//   IDLE
//    - The grant is combinational from req_valid and the pointer.
//    - Search order: ptr, ptr+1, ... (mod NUM_REQ).
//    - req_ready[g] is high in IDLE only; the handshake completes when req_valid[g] & req_ready[g].
//    - On accept: latch key and id; pointer <= g+1 (wraps to 0); go to ISSUE.
//   ISSUE
//    - hf_key_valid = 1 for exactly this cycle; go to BEAT0.
//   BEAT0
//    - On hf_hash_valid: check hf_hash_1[HASH_W-1] == 0; capture lk_idx_a; go to BEAT1.
//   BEAT1
//    - On hf_hash_valid: check hf_hash_1[HASH_W-1] == 1; capture lk_idx_b; go to OUT.
//   OUT
//    - lk_valid = 1 with all lk_* outputs held stable until lk_ready; then go to IDLE.
//  hf_key holds the latched key from ISSUE through BEAT1, because the engine samples the key on both beats.
//  Latency with the engine's 1-cycle response:
//   - accept at cycle T; hf_key_valid at T+1; beats at T+2 and T+3; lk_valid from T+4.
//   - Best-case throughput is one key per 5 cycles.
//  Ordering check: an MSB mismatch in BEAT0 or BEAT1 pulses err_seq for one cycle.
//   - The beat is still captured and the sequence continues, so exactly one descriptor is produced per key.
//  Beats arriving in IDLE, ISSUE or OUT are discarded silently.
//  lk_ready may be high before lk_valid; a descriptor presented with lk_ready already high completes in its first cycle.
//  A requester dropping req_valid before it is granted loses nothing; no grant is issued for it.
//  Reset mid-operation aborts the in-flight key and returns to IDLE.
//   - The requester whose key was in flight must re-present it.
//   - Stray engine beats that arrive after reset are discarded by the IDLE rule.
// CONFIGURATION
//  HASH_TIMEOUT_EN defined:
//   - A cycle counter runs in BEAT0 and BEAT1 and clears on each accepted beat.
//   - When it reaches TIMEOUT_CYC, add output err_timeout: a 1-cycle pulse.
//   - The key is dropped, no descriptor is produced, and the state returns to IDLE.
//  HASH_TIMEOUT_EN undefined: no counter and no err_timeout port; BEAT0/BEAT1 wait indefinitely.
// STRUCTURE
//  Package hash_lookup_pkg:
//   - KEY_W and HASH_W constants.
//   - sched_state_t enum {IDLE, ISSUE, BEAT0, BEAT1, OUT}.
//   - lookup_desc_t struct {id, key, idx_a, idx_b}.
//  Sub-module rr_arbiter (NUM_REQ):
//   - Inputs: req vector, pointer, enable.
//   - Outputs: one-hot grant and encoded index.
//   - Purely combinational; the pointer register stays in the scheduler.
// TESTING
//  - Single key: req_valid=4'b0001, key=40'hF8_0000_0005, behavioural engine model.
//    -> hf_key_valid at T+1; lk_valid at T+4; lk_id=0; lk_idx_a h1=9'h0FD; lk_idx_b h1=9'h1FD.
//  - All four requesters held valid, lk_ready=1 -> grants in order 0,1,2,3,0; one lk_valid every 5 cycles.
//  - Backpressure: lk_ready=0 for 10 cycles in OUT -> lk_* stable; req_ready all 0; descriptor completes on the first lk_ready cycle.
//  - Engine model returns beat MSB 1 then 0 -> err_seq pulses in BEAT0 and in BEAT1; exactly one descriptor is still emitted.
//  - reset=1 for 1 cycle while in BEAT1 -> all outputs 0 and pointer=0; a stray beat afterwards produces no lk_valid.
//  - HASH_TIMEOUT_EN, TIMEOUT_CYC=16, engine silent -> err_timeout 16 cycles after ISSUE; back in IDLE; next requester granted.

Source files
------------

// File: rtl/hash_lookup_pkg.sv
// Shared widths, scheduler state encoding and the lookup descriptor layout.
package hash_lookup_pkg;
  localparam int KEY_W    = 40;
  localparam int HASH_W   = 9;
  localparam int MAX_ID_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BEAT0 = 3'd2,
    BEAT1 = 3'd3,
    OUT   = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [KEY_W-1:0]    key;
    logic [3*HASH_W-1:0] idx_a;
    logic [3*HASH_W-1:0] idx_b;
  } lookup_desc_t;
endpackage

// File: rtl/hash_lookup_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr (mod N).
// Zero latency; grants nothing while en is low.
module rr_arbiter
  import hash_lookup_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/hash_lookup_sched.sv
// Shares one two-beat hash engine among NUM_REQ requesters; accept->lk_valid in 4 cycles, lk_valid held until lk_ready.
// Optional HASH_TIMEOUT_EN adds a beat watchdog (err_timeout) that drops a stalled key.
module hash_lookup_sched
  import hash_lookup_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
`ifdef HASH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*KEY_W-1:0] req_key,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     hf_key_valid,
  output logic [KEY_W-1:0]         hf_key,
  input  logic                     hf_hash_valid,
  input  logic [HASH_W-1:0]        hf_hash_1,
  input  logic [HASH_W-1:0]        hf_hash_2,
  input  logic [HASH_W-1:0]        hf_hash_3,
  output logic                     lk_valid,
  input  logic                     lk_ready,
  output logic [ID_W-1:0]          lk_id,
  output logic [KEY_W-1:0]         lk_key,
  output logic [3*HASH_W-1:0]      lk_idx_a,
  output logic [3*HASH_W-1:0]      lk_idx_b,
  output logic                     err_seq
`ifdef HASH_TIMEOUT_EN
  , output logic                   err_timeout
`endif
);
  sched_state_t        state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  lookup_desc_t        desc_q, desc_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic [3*HASH_W-1:0] beat_idx;
  logic                beat_msb;
  logic                in_beat;
  logic                unused_id;

  // Gating with reset keeps req_ready low while reset is held.
  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (state_q == IDLE && !reset),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign beat_idx = {hf_hash_3, hf_hash_2, hf_hash_1};
  assign beat_msb = hf_hash_1[HASH_W-1];
  assign in_beat  = (state_q == BEAT0) || (state_q == BEAT1);

`ifdef HASH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (in_beat && !hf_hash_valid) cnt_d = cnt_q + 1'b1;
  end

  assign err_timeout = in_beat && !hf_hash_valid && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    desc_d  = desc_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          desc_d.id  = MAX_ID_W'(gnt_idx);
          desc_d.key = req_key[gnt_idx*KEY_W +: KEY_W];
          ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = BEAT0;
      BEAT0: begin
        if (hf_hash_valid) begin
          desc_d.idx_a = beat_idx;
          state_d      = BEAT1;
        end
      end
      BEAT1: begin
        if (hf_hash_valid) begin
          desc_d.idx_b = beat_idx;
          state_d      = OUT;
        end
      end
      OUT:     if (lk_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef HASH_TIMEOUT_EN
    if (err_timeout) state_d = IDLE;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      desc_q  <= desc_d;
    end
  end

  // The engine re-samples the key on both beats, so hf_key stays up through BEAT1.
  assign req_ready    = gnt;
  assign hf_key_valid = (state_q == ISSUE);
  assign hf_key       = (state_q == ISSUE || in_beat) ? desc_q.key : '0;
  assign lk_valid     = (state_q == OUT);
  assign lk_id        = desc_q.id[ID_W-1:0];
  assign lk_key       = desc_q.key;
  assign lk_idx_a     = desc_q.idx_a;
  assign lk_idx_b     = desc_q.idx_b;
  assign err_seq      = hf_hash_valid &&
                        (((state_q == BEAT0) && beat_msb) || ((state_q == BEAT1) && !beat_msb));
  assign unused_id    = ^desc_q.id;
endmodule

// File: tb/tb_hash_lookup_sched.sv
// Bench for hash_lookup_sched: table vectors, hand sequences and a descriptor scoreboard.
`timescale 1ns/1ps
module tb_hash_lookup_sched;
  import hash_lookup_pkg::*;
  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [N-1:0]         req_valid = '0;
  logic [N*KEY_W-1:0]   req_key = '0;
  logic [N-1:0]         req_ready;
  logic                 hf_key_valid;
  logic [KEY_W-1:0]     hf_key;
  logic                 hf_hash_valid = 1'b0;
  logic [HASH_W-1:0]    hf_hash_1 = '0, hf_hash_2 = '0, hf_hash_3 = '0;
  logic                 lk_valid;
  logic                 lk_ready = 1'b1;
  logic [1:0]           lk_id;
  logic [KEY_W-1:0]     lk_key;
  logic [3*HASH_W-1:0]  lk_idx_a, lk_idx_b;
  logic                 err_seq;
`ifdef HASH_TIMEOUT_EN
  logic                 err_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int eng_mode = 0;   // 0 normal, 1 beat MSBs swapped, 2 silent
  bit stray = 1'b0;

  typedef struct {
    logic [1:0]          id;
    logic [KEY_W-1:0]    key;
    logic [3*HASH_W-1:0] a;
    logic [3*HASH_W-1:0] b;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int               req;
    logic [KEY_W-1:0] key;
    logic [8:0]       h1a;
    logic [8:0]       h1b;
  } tv_t;

  hash_lookup_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .hf_key_valid(hf_key_valid), .hf_key(hf_key), .hf_hash_valid(hf_hash_valid),
    .hf_hash_1(hf_hash_1), .hf_hash_2(hf_hash_2), .hf_hash_3(hf_hash_3),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_id(lk_id), .lk_key(lk_key),
    .lk_idx_a(lk_idx_a), .lk_idx_b(lk_idx_b), .err_seq(err_seq)
`ifdef HASH_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3*HASH_W-1:0] eng_hash(input logic [KEY_W-1:0] k, input logic msb);
    logic [7:0] a, b, c;
    a = k[39:32] ^ k[7:0];
    b = k[31:24] ^ k[15:8];
    c = k[23:16];
    return {msb, c, msb, b, msb, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    #1;
    while (!req_ready[i] && n < 30) begin
      tick();
      n++;
    end
    chk("grant", 64'(req_ready[i]), 64'd1);
  endtask

  task automatic check_idle_outputs();
    chk("idle_req_ready", 64'(req_ready), 64'd0);
    chk("idle_hf_key_valid", 64'(hf_key_valid), 64'd0);
    chk("idle_hf_key", 64'(hf_key), 64'd0);
    chk("idle_lk_valid", 64'(lk_valid), 64'd0);
    chk("idle_lk_id", 64'(lk_id), 64'd0);
    chk("idle_lk_key", 64'(lk_key), 64'd0);
    chk("idle_lk_idx", 64'({lk_idx_a, lk_idx_b}), 64'd0);
    chk("idle_err_seq", 64'(err_seq), 64'd0);
  endtask

  // Engine model: answers hf_key_valid with two beats on the next two cycles.
  initial begin : engine
    int pend;
    pend = 0;
    forever begin
      @(posedge clk);
      #1;
      hf_hash_valid = 1'b0;
      if (pend != 0 && eng_mode != 2) begin
        hf_hash_valid = 1'b1;
        {hf_hash_3, hf_hash_2, hf_hash_1} =
          eng_hash(hf_key, (pend == 1) ? (eng_mode == 1) : (eng_mode != 1));
      end else if (stray) begin
        hf_hash_valid = 1'b1;
        {hf_hash_3, hf_hash_2, hf_hash_1} = eng_hash(40'h12_3456_789A, 1'b0);
        stray = 1'b0;
      end
      pend = (pend == 1) ? 2 : 0;
      if (hf_key_valid) pend = 1;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            e.id  = 2'(i);
            e.key = req_key[i*KEY_W +: KEY_W];
            e.a   = eng_hash(e.key, eng_mode == 1);
            e.b   = eng_hash(e.key, eng_mode != 1);
            sb.push_back(e);
          end
        end
        if (lk_valid && lk_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: descriptor id %0d key %0h with nothing pending", lk_id, lk_key);
          end else begin
            e = sb.pop_front();
            chk("sb_id", 64'(lk_id), 64'(e.id));
            chk("sb_key", 64'(lk_key), 64'(e.key));
            chk("sb_idx_a", 64'(lk_idx_a), 64'(e.a));
            chk("sb_idx_b", 64'(lk_idx_b), 64'(e.b));
          end
        end
`ifdef HASH_TIMEOUT_EN
        if (err_timeout && sb.size() > 0) void'(sb.pop_front());
`endif
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    tv_t tv[4];
    int  g_idx[$], g_cyc[$], l_cyc[$];
    int  n, hits;
    bit  early;
    logic [KEY_W-1:0] k;

    tv[0] = '{0, 40'hF8_0000_0005, 9'h0FD, 9'h1FD};
    tv[1] = '{2, 40'h12_0000_0034, 9'h026, 9'h126};
    tv[2] = '{3, 40'hAA_0000_0055, 9'h0FF, 9'h1FF};
    tv[3] = '{1, 40'h00_0000_0000, 9'h000, 9'h100};

    // Reset state, with requesters pushing to show req_ready stays low.
    req_valid = 4'hF;
    tick();
    check_idle_outputs();
    req_valid = '0;
    reset = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      req_key[tv[v].req*KEY_W +: KEY_W] = tv[v].key;
      req_valid = 4'(1 << tv[v].req);
      wait_grant(tv[v].req);
      tick();
      req_valid = '0;
      chk("tv_hf_key_valid", 64'(hf_key_valid), 64'd1);
      chk("tv_hf_key", 64'(hf_key), 64'(tv[v].key));
      tick();
      chk("tv_hf_key_beat0", 64'(hf_key), 64'(tv[v].key));
      tick();
      chk("tv_lk_valid_early", 64'(lk_valid), 64'd0);
      tick();
      chk("tv_lk_valid", 64'(lk_valid), 64'd1);
      chk("tv_lk_id", 64'(lk_id), 64'(tv[v].req));
      chk("tv_idx_a_h1", 64'(lk_idx_a[8:0]), 64'(tv[v].h1a));
      chk("tv_idx_b_h1", 64'(lk_idx_b[8:0]), 64'(tv[v].h1b));
      tick();
    end

    // Round robin from a fresh pointer with all four requesters held valid.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) req_key[i*KEY_W +: KEY_W] = {8'(i + 1), 24'h0, 8'(8'h30 + i)};
    req_valid = 4'hF;
    n = 0;
    #1;
    while (g_idx.size() < 5 && n < 60) begin
      if (|req_ready) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) g_idx.push_back(i);
        g_cyc.push_back(n);
      end
      if (lk_valid) l_cyc.push_back(n);
      if (g_idx.size() == 5) begin
        req_valid = '0;
      end else begin
        tick();
        n++;
      end
    end
    chk("rr_grant_count", 64'(g_idx.size()), 64'd5);
    chk("rr_lk_count", 64'(l_cyc.size()), 64'd4);
    for (int k2 = 0; k2 < 5 && k2 < g_idx.size(); k2++) chk("rr_order", 64'(g_idx[k2]), 64'(k2 % 4));
    for (int k2 = 1; k2 < g_cyc.size(); k2++) chk("rr_interval", 64'(g_cyc[k2] - g_cyc[k2-1]), 64'd5);
    for (int k2 = 0; k2 < l_cyc.size() && k2 < g_cyc.size(); k2++) chk("rr_latency", 64'(l_cyc[k2] - g_cyc[k2]), 64'd4);
    repeat (8) tick();

    // Backpressure: descriptor held for 10 cycles, other requesters locked out.
    k = 40'h5A_0102_0304;
    lk_ready = 1'b0;
    req_key[1*KEY_W +: KEY_W] = k;
    req_valid = 4'b0010;
    wait_grant(1);
    tick();
    req_valid = 4'b1101;
    repeat (3) tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_lk_valid", 64'(lk_valid), 64'd1);
      chk("bp_lk_key", 64'(lk_key), 64'(k));
      chk("bp_lk_idx", 64'({lk_idx_a, lk_idx_b}), 64'({eng_hash(k, 1'b0), eng_hash(k, 1'b1)}));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    lk_ready = 1'b1;
    #1;
    chk("bp_lk_valid_last", 64'(lk_valid), 64'd1);
    tick();
    chk("bp_done", 64'(lk_valid), 64'd0);
    req_valid = '0;
    #1;
    chk("bp_drop_no_grant", 64'(req_ready), 64'd0);
    repeat (3) tick();

    // Out-of-order beat MSBs: both beats flagged, one descriptor still produced.
    eng_mode = 1;
    req_key[3*KEY_W +: KEY_W] = 40'h0F_00FF_00F0;
    req_valid = 4'b1000;
    wait_grant(3);
    tick();
    req_valid = '0;
    chk("seq_none_issue", 64'(err_seq), 64'd0);
    tick();
    chk("seq_beat0", 64'(err_seq), 64'd1);
    tick();
    chk("seq_beat1", 64'(err_seq), 64'd1);
    tick();
    chk("seq_lk_valid", 64'(lk_valid), 64'd1);
    chk("seq_clear", 64'(err_seq), 64'd0);
    eng_mode = 0;
    hits = 0;
    repeat (6) begin
      tick();
      if (lk_valid) hits++;
    end
    chk("seq_single_desc", 64'(hits), 64'd0);

    // Reset while in BEAT1, then a stray beat in IDLE.
    req_key[2*KEY_W +: KEY_W] = 40'h33_4455_6677;
    req_valid = 4'b0100;
    wait_grant(2);
    tick();
    req_valid = '0;
    repeat (2) tick();
    reset = 1'b1;
    req_valid = 4'hF;
    #1;
    check_idle_outputs();
    tick();
    reset = 1'b0;
    req_valid = '0;
    stray = 1'b1;
    hits = 0;
    repeat (8) begin
      tick();
      if (lk_valid) hits++;
    end
    chk("rst_stray_no_desc", 64'(hits), 64'd0);
    req_valid = 4'hF;
    #1;
    chk("rst_ptr_zero", 64'(req_ready), 64'b0001);
    req_valid = '0;
    tick();

`ifdef HASH_TIMEOUT_EN
    // Silent engine: watchdog fires 16 cycles after ISSUE, next requester gets the engine.
    eng_mode = 2;
    req_valid = 4'b0001;
    wait_grant(0);
    tick();
    req_valid = 4'b0011;
    early = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (err_timeout || lk_valid) early = 1'b1;
    end
    chk("tmo_early", 64'(early), 64'd0);
    tick();
    chk("tmo_pulse", 64'(err_timeout), 64'd1);
    eng_mode = 0;
    tick();
    chk("tmo_pulse_clear", 64'(err_timeout), 64'd0);
    chk("tmo_next_grant", 64'(req_ready), 64'b0010);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (6) tick();
`endif

    repeat (10) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
